clk_div_gen: RTL

- Parametrised multi-channel clock divider for board-level clock generation, e.g. the CPU core clock and the seven-segment/scan clock, from the board oscillator.
- Each channel has:
  - a runtime-loadable half-period divisor, updated glitch-free;
  - a run/halt control;
  - a single-step mode that emits exactly one output period, used for stepping the pipeline during debug.
- Each channel also drives a one-cycle tick (clock-enable) output, for logic that stays on clk.

---
 rtl/clk_div_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/clk_div_gen.sv
// Multi-channel runtime-programmable clock divider with run/halt and single-step control.
// Each channel emits a 50% duty clock plus a one-cycle tick on every rising edge.
module clk_div_gen #(
   parameter int                 NCH      = 2,
   parameter int                 W        = 26,
   parameter logic [NCH*W-1:0]   DIV_INIT = {26'd100000, 26'd1},
   parameter logic [NCH-1:0]     RUN_INIT = 2'b11,
   localparam int                SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] run_en,
   input  logic [NCH-1:0] step,
   input  logic           div_we,
   input  logic [SW-1:0]  div_sel,
   input  logic [W-1:0]   div_wdata,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] busy
);

   typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t        state;
      logic [W-1:0]  count;
      logic [W-1:0]  div_act;
      logic [W-1:0]  div_pend;
      logic [W-1:0]  lim;
      logic          term;
      logic          clk_q;
      logic          tick_q;
      logic          busy_q;
      logic          wr_hit;

      always_comb begin
         lim    = (div_act == '0) ? W'(1) : div_act;
         term   = (count == lim - W'(1));
         wr_hit = div_we && (int'(div_sel) == i);
      end

      // div_act only changes at a terminal count or while idle, so phases are never cut short.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state    <= RUN_INIT[i] ? RUN : IDLE;
            busy_q   <= RUN_INIT[i];
            count    <= '0;
            div_act  <= DIV_INIT[i*W +: W];
            div_pend <= DIV_INIT[i*W +: W];
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (wr_hit)
               div_pend <= div_wdata;
            case (state)
               IDLE: begin
                  count   <= '0;
                  clk_q   <= 1'b0;
                  div_act <= div_pend;
                  if (run_en[i]) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end else if (step[i]) begin
                     state  <= STEP;
                     busy_q <= 1'b1;
                  end
               end
               RUN, STEP: begin
                  if (term) begin
                     count   <= '0;
                     div_act <= div_pend;
                     if (clk_q) begin
                        clk_q <= 1'b0;
                        if (state == STEP) begin
                           state  <= IDLE;
                           busy_q <= 1'b0;
                        end
                     end else if (state == STEP || run_en[i]) begin
                        clk_q  <= 1'b1;
                        tick_q <= 1'b1;
                     end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                     end
                  end else begin
                     count <= count + W'(1);
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end

      assign clk_out[i] = clk_q;
      assign tick[i]    = tick_q;
      assign busy[i]    = busy_q;
   end

endmodule
